// File: rtl/bat_amateur_bus_arbiter.sv
// Round-robin bus/RAM arbiter with a one-cycle turnaround between owners.
// Optional forced release after HOLD_MAX grant cycles: define ARB_TIMEOUT_EN.
module bat_amateur_bus_arbiter #(
    parameter  int NUM_REQ  = 4,
    parameter  int HOLD_MAX = 16,
    localparam int IDXW     = $clog2(NUM_REQ)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NUM_REQ-1:0] REQ,
    output logic [NUM_REQ-1:0] GNT,
    output logic               BUS_EN,
    output logic [IDXW-1:0]    OWNER,
    output logic               CPU_STALL,
    output logic               TIMEOUT
);

    typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               bus_en_q;
    logic [IDXW-1:0]    owner_q, owner_d;
    logic [IDXW-1:0]    ptr_q, ptr_d;
    logic [IDXW-1:0]    win;
    logic [IDXW-1:0]    idx;
    logic [IDXW-1:0]    owner_next;
    logic               found;
    int                 s;

    generate
        if (NUM_REQ < 2 || HOLD_MAX < 1) begin : g_param_check
            $error("bat_amateur_bus_arbiter: NUM_REQ must be >= 2 and HOLD_MAX >= 1");
        end
    endgenerate

    // First requester at or after ptr, wrapping; NUM_REQ need not be a power of two.
    always_comb begin
        win   = '0;
        idx   = '0;
        found = 1'b0;
        s     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            s = int'(ptr_q) + i;
            if (s >= NUM_REQ) s = s - NUM_REQ;
            idx = IDXW'(s);
            if (!found && REQ[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign owner_next = (owner_q == IDXW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

`ifdef ARB_TIMEOUT_EN
    localparam int HCW = $clog2(HOLD_MAX + 1);
    logic [HCW-1:0] hold_q, hold_d;
    logic           timeout_q, timeout_d;
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
`ifdef ARB_TIMEOUT_EN
        hold_d    = hold_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            GRANT: begin
                if (!REQ[owner_q]) begin
                    gnt_d   = '0;
                    ptr_d   = owner_next;
                    state_d = TURN;
                end
`ifdef ARB_TIMEOUT_EN
                else if (hold_q == HCW'(HOLD_MAX - 1)) begin
                    gnt_d     = '0;
                    ptr_d     = owner_next;
                    timeout_d = 1'b1;
                    state_d   = TURN;
                end else if (hold_q != HCW'(HOLD_MAX)) begin
                    hold_d = hold_q + 1'b1;
                end
`endif
            end
            default: begin
                if (found) begin
                    gnt_d   = {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
                    owner_d = win;
                    state_d = GRANT;
`ifdef ARB_TIMEOUT_EN
                    hold_d  = '0;
`endif
                end else begin
                    gnt_d   = '0;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            bus_en_q <= 1'b0;
            owner_q  <= '0;
            ptr_q    <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            bus_en_q <= |gnt_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end
    assign TIMEOUT = timeout_q;
`else
    assign TIMEOUT = 1'b0;
`endif

    assign GNT       = gnt_q;
    assign BUS_EN    = bus_en_q;
    assign OWNER     = owner_q;
    assign CPU_STALL = REQ[0] & ~gnt_q[0];

endmodule

// File: tb/tb_bat_amateur_bus_arbiter.sv
// Scoreboard bench for bat_amateur_bus_arbiter; cycle model pushes expected
// outputs as each REQ pattern is driven, popped after the following edge.
module tb_bat_amateur_bus_arbiter;

    localparam int NR = 4;
    localparam int HM = 16;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          CLK;
    logic          RST;
    logic [NR-1:0] REQ;
    logic [NR-1:0] GNT;
    logic          BUS_EN;
    logic [1:0]    OWNER;
    logic          CPU_STALL;
    logic          TIMEOUT;

    bat_amateur_bus_arbiter #(.NUM_REQ(NR), .HOLD_MAX(HM)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .GNT(GNT), .BUS_EN(BUS_EN),
        .OWNER(OWNER), .CPU_STALL(CPU_STALL), .TIMEOUT(TIMEOUT)
    );

    typedef struct {
        logic [NR-1:0] gnt;
        logic          bus;
        logic [1:0]    owner;
        logic          to;
    } exp_t;

    exp_t exp_q[$];
    int   order_q[$];

    int checks   = 0;
    int failures = 0;

    // reference model
    bit m_valid;
    int m_owner, m_ptr, m_hold;
    int gcnt;
    logic [NR-1:0] prev_gnt;
    int  idle_run;
    bit  gap_armed;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h required=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_owner = 0; m_ptr = 0; m_hold = 0; gcnt = 0;
        prev_gnt = '0; idle_run = 0; gap_armed = 0;
    endtask

    task automatic step(input logic [NR-1:0] r);
        exp_t e;
        bit   to;
        bit   hit;
        int   w;
        REQ = r;
        #1;
        chk("cpu_stall", {31'd0, CPU_STALL}, {31'd0, r[0] & ~(m_valid && m_owner == 0)});
        to = 0;
        if (m_valid) begin
            if (r[m_owner] && !(TO_EN && m_hold == HM - 1)) begin
                if (m_hold < HM) m_hold++;
            end else begin
                to      = r[m_owner];
                m_valid = 0;
                m_ptr   = (m_owner + 1) % NR;
            end
        end else if (r != 0) begin
            hit = 0;
            for (int k = 0; k < NR; k++) begin
                w = (m_ptr + k) % NR;
                if (!hit && r[w]) begin
                    hit = 1; m_valid = 1; m_owner = w; m_hold = 0;
                end
            end
        end
        e.gnt   = m_valid ? (NR'(1) << m_owner) : '0;
        e.bus   = m_valid;
        e.owner = 2'(m_owner);
        e.to    = to;
        exp_q.push_back(e);
        gcnt = m_valid ? gcnt + 1 : 0;

        @(posedge CLK);
        #1;
        e = exp_q.pop_front();
        chk("gnt",     {28'd0, GNT},     {28'd0, e.gnt});
        chk("bus_en",  {31'd0, BUS_EN},  {31'd0, e.bus});
        chk("owner",   {30'd0, OWNER},   {30'd0, e.owner});
        chk("timeout", {31'd0, TIMEOUT}, {31'd0, e.to});

        if (prev_gnt == '0 && GNT != '0 && order_q.size() > 0) begin
            chk("order", {30'd0, OWNER}, order_q.pop_front());
            if (gap_armed) chk("gap", idle_run, 1);
            gap_armed = 1;
        end
        idle_run = (GNT == '0) ? idle_run + 1 : 0;
        prev_gnt = GNT;
    endtask

    task automatic do_reset(input logic [NR-1:0] r);
        REQ = r;
        @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("rst_gnt",   {28'd0, GNT},     32'd0);
        chk("rst_bus",   {31'd0, BUS_EN},  32'd0);
        chk("rst_owner", {30'd0, OWNER},   32'd0);
        chk("rst_to",    {31'd0, TIMEOUT}, 32'd0);
        @(posedge CLK);
        #1;
        chk("rst_hold_gnt", {28'd0, GNT}, 32'd0);
        model_reset();
        RST = 1'b0;
    endtask

    int run, pulses;

    initial begin
        RST = 1'b1;
        REQ = 4'b1111;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;

        // 1: reset with all requesting, then release idle
        do_reset(4'b1111);
        REQ = '0;
        repeat (3) step(4'b0000);

        // 2: single requester, grant latency and one-cycle turnaround
        step(4'b0010);
        chk("t2_gnt", {28'd0, GNT}, 32'h2);
        step(4'b0010);
        step(4'b0000);
        chk("t2_turn", {28'd0, GNT}, 32'h0);
        step(4'b0000);

        // 3: full rotation from ptr=0
        do_reset(4'b0000);
        order_q = '{0, 1, 2, 3, 0};
        for (int c = 0; c < 15; c++) begin
            logic [NR-1:0] r;
            r = 4'b1111;
            if (m_valid && gcnt >= 2) r[m_owner] = 1'b0;
            step(r);
        end
        chk("t3_order_done", order_q.size(), 0);

        // 4: owner 3 releases, wrap to 0
        step(4'b1000);
        step(4'b1000);
        step(4'b1000);
        chk("t4_owner3", {28'd0, GNT}, 32'h8);
        step(4'b0001);
        chk("t4_turn_stall", {31'd0, CPU_STALL}, 32'd1);
        step(4'b1001);
        chk("t4_wrap_gnt", {28'd0, GNT}, 32'h1);
        step(4'b0000);
        step(4'b0000);

`ifdef ARB_TIMEOUT_EN
        // 5: forced release after HM cycles, re-grant after one idle cycle
        run = 0; pulses = 0;
        for (int c = 0; c < 40; c++) begin
            step(4'b0100);
            if (GNT[2]) run++;
            else begin
                if (TIMEOUT) begin
                    chk("t5_hold_len", run, HM);
                    pulses++;
                end
                run = 0;
            end
        end
        chk("t5_pulses", pulses, 2);
        step(4'b0000);
        step(4'b0000);
`endif

        // 6: async reset mid-grant of owner 1
        step(4'b0010);
        step(4'b0010);
        chk("t6_pre", {28'd0, GNT}, 32'h2);
        REQ = 4'b0011;
        #2;
        RST = 1'b1;
        #1;
        chk("t6_async_gnt", {28'd0, GNT},    32'h0);
        chk("t6_async_bus", {31'd0, BUS_EN}, 32'd0);
        @(posedge CLK);
        #1;
        model_reset();
        RST = 1'b0;
        step(4'b0011);
        chk("t6_after_rst", {28'd0, GNT}, 32'h1);
        step(4'b0011);
        step(4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
